// File: rtl/load_store_unit.sv
// Load/store unit: turns CPU byte/half/word requests into word-only memory
// accesses, using a read-modify-write sequence for sub-word stores.
module load_store_unit #(
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cpu_valid_in,
    input  logic [31:0] cpu_addr_in,
    input  logic [31:0] cpu_wdata_in,
    input  logic        cpu_re_in,
    input  logic        cpu_we_in,
    input  logic [1:0]  cpu_size_in,
    input  logic        cpu_signed_in,
    output logic        cpu_ready_out,
    output logic        cpu_done_out,
    output logic        cpu_fault_out,
    output logic [31:0] cpu_rdata_out,
    output logic [31:0] mem_addr_out,
    output logic [31:0] mem_wdata_out,
    output logic        mem_re_out,
    output logic        mem_we_out,
    output logic [1:0]  mem_size_out,
    input  logic [31:0] mem_rdata_in
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ST_WR,
        RMW_RD,
        RMW_WR,
        DONE
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b11;

    state_t      state;
    state_t      state_nx;

    logic [1:0]  off_q;
    logic [15:0] wdata_q;
    logic [1:0]  size_q;
    logic        signed_q;
    logic        fault_q;
    logic [31:0] rdata_q;
    logic [31:0] mem_addr_q;
    logic [31:0] mem_wdata_q;

    logic        accept;
    logic        req_fault;
    logic        req_noop;
    logic [4:0]  sh;
    logic [31:0] lane_raw;
    logic [31:0] load_ext;
    logic [31:0] lane_mask;
    logic [31:0] lane_ins;
    logic [31:0] merged;

    // Bit position of the addressed byte/halfword within the memory word.
    function automatic logic [4:0] lane_shift(input logic [1:0] off, input logic [1:0] sz);
        logic [4:0] s;
        s = '0;
        if (sz == SZ_BYTE) begin
            s = BIG_ENDIAN ? {~off, 3'b000} : {off, 3'b000};
        end else if (sz == SZ_HALF) begin
            s = BIG_ENDIAN ? {~off[1], 4'b0000} : {off[1], 4'b0000};
        end
        return s;
    endfunction

    assign accept    = (state == IDLE) && cpu_valid_in;
    assign req_noop  = !cpu_re_in && !cpu_we_in;
    assign req_fault = (cpu_size_in == 2'b10)
                    || ((cpu_size_in == SZ_HALF) && cpu_addr_in[0])
                    || ((cpu_size_in == SZ_WORD) && (cpu_addr_in[1:0] != 2'b00))
                    || (cpu_re_in && cpu_we_in);

    assign sh       = lane_shift(off_q, size_q);
    assign lane_raw = mem_rdata_in >> sh;

    always_comb begin
        load_ext = mem_rdata_in;
        if (size_q == SZ_BYTE) begin
            load_ext = signed_q ? {{24{lane_raw[7]}}, lane_raw[7:0]} : {24'h0, lane_raw[7:0]};
        end else if (size_q == SZ_HALF) begin
            load_ext = signed_q ? {{16{lane_raw[15]}}, lane_raw[15:0]} : {16'h0, lane_raw[15:0]};
        end
    end

    always_comb begin
        lane_mask = '0;
        lane_ins  = '0;
        if (size_q == SZ_BYTE) begin
            lane_mask = 32'h0000_00FF << sh;
            lane_ins  = {24'h0, wdata_q[7:0]} << sh;
        end else begin
            lane_mask = 32'h0000_FFFF << sh;
            lane_ins  = {16'h0, wdata_q} << sh;
        end
        merged = (mem_rdata_in & ~lane_mask) | lane_ins;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (cpu_valid_in) begin
                    if (req_fault || req_noop)     state_nx = DONE;
                    else if (cpu_re_in)            state_nx = LOAD;
                    else if (cpu_size_in == SZ_WORD) state_nx = ST_WR;
                    else                           state_nx = RMW_RD;
                end
            end
            LOAD:    state_nx = DONE;
            ST_WR:   state_nx = DONE;
            RMW_RD:  state_nx = RMW_WR;
            RMW_WR:  state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            off_q       <= '0;
            wdata_q     <= '0;
            size_q      <= '0;
            signed_q    <= 1'b0;
            fault_q     <= 1'b0;
            rdata_q     <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                off_q    <= cpu_addr_in[1:0];
                wdata_q  <= cpu_wdata_in[15:0];
                size_q   <= cpu_size_in;
                signed_q <= cpu_signed_in;
                fault_q  <= req_fault;
                // Memory-side registers only move for requests that really access memory.
                if (!req_fault && !req_noop) begin
                    mem_addr_q <= {cpu_addr_in[31:2], 2'b00};
                    if (cpu_we_in && (cpu_size_in == SZ_WORD)) begin
                        mem_wdata_q <= cpu_wdata_in;
                    end
                end
            end
            if (state == LOAD) begin
                rdata_q <= load_ext;
            end
            if (state == RMW_RD) begin
                mem_wdata_q <= merged;
            end
        end
    end

    assign cpu_ready_out = (state == IDLE);
    assign cpu_done_out  = (state == DONE);
    assign cpu_fault_out = (state == DONE) && fault_q;
    assign cpu_rdata_out = rdata_q;
    assign mem_addr_out  = mem_addr_q;
    assign mem_wdata_out = mem_wdata_q;
    assign mem_re_out    = (state == LOAD) || (state == RMW_RD);
    assign mem_we_out    = (state == ST_WR) || (state == RMW_WR);
    assign mem_size_out  = SZ_WORD;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: directed requests against a small
// word memory model; a negedge monitor checks every done pulse.
module tb_load_store_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        cpu_valid_in = 1'b0;
    logic [31:0] cpu_addr_in = '0;
    logic [31:0] cpu_wdata_in = '0;
    logic        cpu_re_in = 1'b0;
    logic        cpu_we_in = 1'b0;
    logic [1:0]  cpu_size_in = '0;
    logic        cpu_signed_in = 1'b0;
    logic        cpu_ready_out;
    logic        cpu_done_out;
    logic        cpu_fault_out;
    logic [31:0] cpu_rdata_out;
    logic [31:0] mem_addr_out;
    logic [31:0] mem_wdata_out;
    logic        mem_re_out;
    logic        mem_we_out;
    logic [1:0]  mem_size_out;
    logic [31:0] mem_rdata_in;

    load_store_unit #(.BIG_ENDIAN(1'b1)) dut (
        .clock(clock), .reset(reset),
        .cpu_valid_in(cpu_valid_in), .cpu_addr_in(cpu_addr_in), .cpu_wdata_in(cpu_wdata_in),
        .cpu_re_in(cpu_re_in), .cpu_we_in(cpu_we_in), .cpu_size_in(cpu_size_in),
        .cpu_signed_in(cpu_signed_in), .cpu_ready_out(cpu_ready_out), .cpu_done_out(cpu_done_out),
        .cpu_fault_out(cpu_fault_out), .cpu_rdata_out(cpu_rdata_out), .mem_addr_out(mem_addr_out),
        .mem_wdata_out(mem_wdata_out), .mem_re_out(mem_re_out), .mem_we_out(mem_we_out),
        .mem_size_out(mem_size_out), .mem_rdata_in(mem_rdata_in)
    );

    always #5 clock = ~clock;

    // Word memory indexed by address bits [5:2]; backdoor port for preloading.
    logic [31:0] mem [16];
    logic        tb_wr_en = 1'b0;
    logic [3:0]  tb_wr_idx = '0;
    logic [31:0] tb_wr_data = '0;

    assign mem_rdata_in = mem[mem_addr_out[5:2]];

    always @(posedge clock) begin
        if (tb_wr_en) mem[tb_wr_idx] <= tb_wr_data;
        else if (mem_we_out) mem[mem_addr_out[5:2]] <= mem_wdata_out;
    end

    typedef struct {
        logic        f;
        logic [31:0] rd;
        logic        crd;
        string       nm;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    always @(negedge clock) begin
        exp_t e;
        if (cpu_done_out) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_done: got done=1 expected no pending request");
            end else begin
                e = sb.pop_front();
                check({e.nm, "_fault"}, {31'h0, cpu_fault_out}, {31'h0, e.f});
                if (e.crd) check({e.nm, "_rdata"}, cpu_rdata_out, e.rd);
            end
        end
    end

    task automatic poke(input logic [3:0] idx, input logic [31:0] d);
        @(negedge clock);
        tb_wr_en = 1'b1; tb_wr_idx = idx; tb_wr_data = d;
        @(posedge clock);
        #1 tb_wr_en = 1'b0;
    endtask

    // Issues one request and observes it until done (bounded).
    task automatic issue(input string nm, input logic [31:0] a, input logic [31:0] wd,
                         input logic re, input logic we, input logic [1:0] sz, input logic sg,
                         input logic hold, input logic ef, input logic [31:0] erd, input logic crd,
                         output int lat, output int nre, output int nwe, output int nrdy,
                         output logic [31:0] wv, output logic [31:0] av);
        int b;
        b = 0;
        while (!cpu_ready_out && b < 20) begin
            @(negedge clock);
            b++;
        end
        cpu_addr_in = a; cpu_wdata_in = wd; cpu_re_in = re; cpu_we_in = we;
        cpu_size_in = sz; cpu_signed_in = sg; cpu_valid_in = 1'b1;
        sb.push_back('{ef, erd, crd, nm});
        @(posedge clock);
        #1 cpu_valid_in = hold;
        lat = 0; nre = 0; nwe = 0; nrdy = 0; wv = '0; av = '0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clock);
            if (cpu_ready_out) nrdy++;
            if (mem_re_out) begin nre++; av = mem_addr_out; end
            if (mem_we_out) begin nwe++; wv = mem_wdata_out; av = mem_addr_out; end
            if (cpu_done_out) begin lat = i; break; end
        end
        cpu_valid_in = 1'b0;
        if (lat == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s_timeout: got no done expected done within 10 cycles", nm);
        end
    endtask

    int lat, nre, nwe, nrdy, cnt;
    logic [31:0] wv, av;

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        check("rst_ready", {31'h0, cpu_ready_out}, 32'h1);
        check("rst_done_fault", {30'h0, cpu_done_out, cpu_fault_out}, 32'h0);
        check("rst_rdata", cpu_rdata_out, 32'h0);
        check("rst_mem_en", {30'h0, mem_re_out, mem_we_out}, 32'h0);
        check("rst_mem_addr", mem_addr_out, 32'h0);
        check("rst_mem_wdata", mem_wdata_out, 32'h0);
        @(negedge clock);
        reset = 1'b1;

        poke(4'd1, 32'h8122_A344);
        issue("lb", 32'h1000_0004, 0, 1, 0, 2'b00, 1, 0, 0, 32'hFFFF_FF81, 1, lat, nre, nwe, nrdy, wv, av);
        check("lb_lat", lat, 2);
        check("lb_acc", {nre[15:0], nwe[15:0]}, {16'd1, 16'd0});
        check("lb_addr", av, 32'h1000_0004);
        issue("lbu", 32'h1000_0004, 0, 1, 0, 2'b00, 0, 0, 0, 32'h0000_0081, 1, lat, nre, nwe, nrdy, wv, av);
        issue("lh", 32'h1000_0006, 0, 1, 0, 2'b01, 1, 0, 0, 32'hFFFF_A344, 1, lat, nre, nwe, nrdy, wv, av);
        issue("lhu", 32'h1000_0004, 0, 1, 0, 2'b01, 0, 0, 0, 32'h0000_8122, 1, lat, nre, nwe, nrdy, wv, av);
        issue("lw", 32'h1000_0004, 0, 1, 0, 2'b11, 0, 0, 0, 32'h8122_A344, 1, lat, nre, nwe, nrdy, wv, av);
        issue("lb7", 32'h1000_0007, 0, 1, 0, 2'b00, 1, 0, 0, 32'h0000_0044, 1, lat, nre, nwe, nrdy, wv, av);
        issue("noop", 32'h1000_0004, 0, 0, 0, 2'b11, 0, 0, 0, 32'h0000_0044, 1, lat, nre, nwe, nrdy, wv, av);
        check("noop_lat", lat, 1);
        check("noop_acc", nre + nwe, 0);

        poke(4'd1, 32'h1122_3344);
        issue("sb", 32'h1000_0005, 32'h0000_00AB, 0, 1, 2'b00, 0, 0, 0, 0, 0, lat, nre, nwe, nrdy, wv, av);
        check("sb_lat", lat, 3);
        check("sb_acc", {nre[15:0], nwe[15:0]}, {16'd1, 16'd1});
        check("sb_wdata", wv, 32'h11AB_3344);
        check("sb_mem", mem[1], 32'h11AB_3344);

        issue("lw_misal", 32'h1000_0002, 0, 1, 0, 2'b11, 0, 0, 1, 0, 0, lat, nre, nwe, nrdy, wv, av);
        check("misal_lat", lat, 1);
        check("misal_acc", nre + nwe, 0);
        issue("sz10", 32'h1000_0004, 0, 1, 0, 2'b10, 0, 0, 1, 0, 0, lat, nre, nwe, nrdy, wv, av);
        issue("sh_odd", 32'h1000_0005, 0, 0, 1, 2'b01, 0, 0, 1, 0, 0, lat, nre, nwe, nrdy, wv, av);
        check("sh_odd_acc", nre + nwe, 0);
        issue("re_we", 32'h1000_0004, 0, 1, 1, 2'b11, 0, 0, 1, 0, 0, lat, nre, nwe, nrdy, wv, av);
        check("re_we_acc", nre + nwe, 0);

        // Halfword store abandoned by reset in its read phase (no scoreboard entry).
        poke(4'd0, 32'h1122_3344);
        @(negedge clock);
        cpu_addr_in = 32'h1000_0000; cpu_wdata_in = 32'h0000_BEEF; cpu_re_in = 0; cpu_we_in = 1;
        cpu_size_in = 2'b01; cpu_signed_in = 0; cpu_valid_in = 1;
        @(posedge clock);
        #1 cpu_valid_in = 1'b0;
        @(negedge clock);
        check("rmw_rd_re", {30'h0, mem_re_out, mem_we_out}, 32'h2);
        #1 reset = 1'b0;
        #1;
        check("midrst_ready", {31'h0, cpu_ready_out}, 32'h1);
        check("midrst_mem_addr", mem_addr_out, 32'h0);
        cnt = 0;
        repeat (2) begin
            @(negedge clock);
            if (mem_we_out || cpu_done_out) cnt++;
        end
        reset = 1'b1;
        check("midrst_no_we", cnt, 0);
        check("midrst_mem", mem[0], 32'h1122_3344);

        issue("sw", 32'h7FFF_FFFC, 32'hDEAD_BEEF, 0, 1, 2'b11, 0, 1, 0, 0, 0, lat, nre, nwe, nrdy, wv, av);
        check("sw_lat", lat, 2);
        check("sw_acc", {nre[15:0], nwe[15:0]}, {16'd0, 16'd1});
        check("sw_wdata", wv, 32'hDEAD_BEEF);
        check("sw_addr", av, 32'h7FFF_FFFC);
        check("sw_busy", nrdy, 0);
        issue("lw_back", 32'h7FFF_FFFC, 0, 1, 0, 2'b11, 0, 1, 0, 32'hDEAD_BEEF, 1, lat, nre, nwe, nrdy, wv, av);
        check("lwb_lat", lat, 2);
        check("lwb_acc", {nre[15:0], nwe[15:0]}, {16'd1, 16'd0});
        check("lwb_busy", nrdy, 0);

        cnt = 0;
        repeat (4) begin
            @(negedge clock);
            if (mem_re_out || mem_we_out) cnt++;
        end
        check("idle_no_acc", cnt, 0);
        check("sb_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter: BIG_ENDIAN, default 1; byte lane order; 1 = byte offset 0 maps to bits [31:24].
REQ-002 clock  input  1  single clock; all state changes on the rising edge.
REQ-003 reset  input  1  asynchronous, active-low; asserting it (low) clears all state at once, with no clock edge needed.
REQ-004 cpu_valid_in  input  1  request strobe; sampled only while cpu_ready_out=1.
REQ-005 cpu_addr_in  input  32  byte address.
REQ-006 cpu_wdata_in  input  32  store data, right-justified for byte and halfword stores.
REQ-007 cpu_re_in / cpu_we_in  input  1 each  load / store select.
REQ-008 cpu_size_in  input  2  00 = byte, 01 = half, 11 = word, 10 = illegal.
REQ-009 cpu_signed_in  input  1  1 = sign-extend a sub-word load; 0 = zero-extend.
REQ-010 cpu_ready_out  output  1  high only in IDLE.
REQ-011 cpu_done_out  output  1  one-cycle completion pulse.
REQ-012 cpu_fault_out  output  1  qualifies cpu_done_out; request rejected.
REQ-013 cpu_rdata_out  output  32  load result; held until the next request is accepted.
REQ-014 mem_addr_out  output  32  word-aligned address to data memory ({addr[31:2],2'b00}).
REQ-015 mem_wdata_out  output  32  full-word write data.
REQ-016 mem_re_out / mem_we_out  output  1 each  memory read / write enables.
REQ-017 mem_size_out  output  2  tied to 2'b11; the downstream memory accepts word accesses only.
REQ-018 mem_rdata_in  input  32  memory read data, combinational within the cycle mem_re_out is high.

Function
REQ-019 States: IDLE, LOAD, ST_WR, RMW_RD, RMW_WR, DONE.
REQ-020 Acceptance: a request is accepted when cpu_valid_in=1 in IDLE (cycle T); address, data, size, signed and op are latched.
REQ-021 Fault on accept: the request faults if any of these holds; no memory access occurs, and DONE at T+1 has cpu_fault_out=1.
  - size=10
  - half with addr[0]=1
  - word with addr[1:0]!=0
  - re=we=1
REQ-022 No-op: a request with re=we=0 goes straight to DONE at T+1 with fault=0 and no memory access.
REQ-023 Load path: LOAD at T+1 with mem_re_out=1; result captured at the end of T+1; DONE at T+2.
REQ-024 Word store path: ST_WR at T+1 with mem_we_out=1 and mem_wdata_out=wdata; DONE at T+2.
REQ-025 Sub-word store, read phase: RMW_RD at T+1 with mem_re_out=1; the target lane(s) of mem_rdata_in are replaced with wdata[7:0] or wdata[15:0]; the merged word is registered.
REQ-026 Sub-word store, write phase: RMW_WR at T+2 with mem_we_out=1 writing the merged word; DONE at T+3.
REQ-027 Load extraction: select the byte or halfword by addr[1:0] per BIG_ENDIAN; extend to 32 bits per cpu_signed_in; word loads pass through unchanged.
REQ-028 DONE lasts exactly one cycle with cpu_done_out=1, then returns to IDLE; a new request is accepted no earlier than the cycle after DONE.
REQ-029 mem_re_out and mem_we_out are never high together, and are high only in the states named above.
REQ-030 mem_addr_out and mem_wdata_out hold their last values when idle.
REQ-031 cpu_fault_out is 0 except during a faulting DONE.
REQ-032 cpu_valid_in is ignored while cpu_ready_out=0; no queuing.

Reset
REQ-033 While reset=0: state=IDLE, cpu_ready_out=1, and these outputs are 0: cpu_done_out, cpu_fault_out, cpu_rdata_out, mem_re_out, mem_we_out, mem_addr_out, mem_wdata_out.
REQ-034 Reset mid-operation: reset asserted in any state abandons the request, with no done pulse. In RMW_RD, no write ever issues; in ST_WR or RMW_WR, mem_we_out drops immediately.
REQ-035 First acceptance after reset: possible on the first rising edge with reset=1.

Verification
REQ-036 Word 0x10000004=0x8122A344, three loads, all fault=0:
  - lb signed @0x10000004 -> 0xFFFFFF81 at T+2
  - lbu @0x10000004 -> 0x00000081
  - lh signed @0x10000006 -> 0xFFFFA344
REQ-037 Word 0x10000004=0x11223344; sb @0x10000005 with wdata 0x000000AB -> mem_re at T+1, mem_we at T+2 with mem_wdata 0x11AB3344, done at T+3, memory reads 0x11AB3344.
REQ-038 lw @0x10000002 -> done with fault=1 at T+1; mem_re/mem_we stay 0 for the whole transaction.
REQ-039 sh @0x10000000 with wdata 0x0000BEEF over 0x11223344; reset pulsed low during RMW_RD -> mem_we never asserts; memory stays 0x11223344; ready=1 after reset.
REQ-040 sw @0x7FFFFFFC with 0xDEADBEEF, then lw @0x7FFFFFFC issued on the cycle after DONE -> cpu_rdata_out=0xDEADBEEF; ready low during each request; cpu_valid_in held high while busy causes no extra accesses.
